// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans the enabled channels of a downstream 4:1 mux and captures y per channel.
// Ports: clk, rst (async, active high); start/mask request a scan; y is the mux output;
// {s1,s0} select the mux channel; busy is high while settling; sample/valid hand the
// captured bits to the consumer, which takes them with ready.
// Macro SCAN_CONT_EN: when defined, DONE relaunches a scan with the current mask after handoff.
module mux_scan_ctrl #(
  parameter int DWELL = 3,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [3:0] sample,
  output logic       valid,
  input  logic       ready
);
  localparam int D = (DWELL < 1) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d, sample_q, sample_d;
  logic busy_q, busy_d, valid_q, valid_d, launch;
  logic [2:0] first, next;
  // Returns {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [2:0] pick(input logic [3:0] m, input int lo);
    pick = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && i >= lo) pick = {1'b1, 2'(i)};
  endfunction
  assign first = pick(mask, 0);
  assign next = pick(mask_q, int'(sel_q) + 1);
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    mask_d = mask_q;
    sample_d = sample_q;
    launch = 1'b0;
    if (state_q == IDLE) begin
      launch = start && first[2];
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        sample_d[sel_q] = y;
        cnt_d = '0;
        if (next[2]) sel_d = next[1:0];
        else state_d = DONE;
      end
    end else if (ready) begin
      state_d = IDLE;
`ifdef SCAN_CONT_EN
      launch = first[2];
`endif
    end
    if (launch) begin
      mask_d = mask;
      sample_d = '0;
      sel_d = first[1:0];
      cnt_d = '0;
      state_d = SETTLE;
    end
    busy_d = state_d == SETTLE;
    valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      mask_q <= '0;
      sample_q <= '0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      sample_q <= sample_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign {s1, s0} = sel_q;
  assign busy = busy_q;
  assign sample = sample_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed and randomized checks of mux_scan_ctrl against a queue-based model.
module tb_mux_scan_ctrl;
  localparam int DWELL = 3;
  logic clk = 1'b0, rst, start, y, ready, s1, s0, busy, valid;
  logic [3:0] mask, sample, ypat;
  int tests = 0, fails = 0;
  logic [1:0] m_sel;
  logic m_busy, m_valid;
  logic [3:0] m_sample;
  int q[$];
  always #5 clk = ~clk;
  // Emulates the downstream 4:1 mux: ypat holds the data presented on each channel.
  assign y = ypat[{s1, s0}];
  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mask(mask), .y(y), .s1(s1), .s0(s0),
    .busy(busy), .sample(sample), .valid(valid), .ready(ready)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  // The model plans a scan as a list of per-cycle selects; the last cycle of each dwell captures.
  task automatic m_launch(input logic [3:0] mk);
    q.delete();
    for (int c = 0; c < 4; c++)
      if (mk[c]) for (int d = 0; d < DWELL; d++) q.push_back(c * 2 + int'(d == DWELL - 1));
    m_sel = 2'(q[0] / 2);
    m_sample = 4'b0;
    m_busy = 1'b1;
  endtask
  initial begin
    int e;
    m_sel = 0; m_busy = 0; m_valid = 0; m_sample = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_sel = 0; m_busy = 0; m_valid = 0; m_sample = 0;
        q.delete();
      end else if (m_busy) begin
        e = q.pop_front();
        if (e % 2 == 1) m_sample[e / 2] = ypat[e / 2];
        if (q.size() == 0) begin
          m_busy = 0;
          m_valid = 1;
        end else m_sel = 2'(q[0] / 2);
      end else if (m_valid) begin
        if (ready) begin
          m_valid = 0;
`ifdef SCAN_CONT_EN
          if (mask != 0) m_launch(mask);
`endif
        end
      end else if (start && mask != 0) m_launch(mask);
    end
  end
  initial forever begin
    @(negedge clk);
    chk("sel", {s1, s0}, m_sel);
    chk("busy", busy, m_busy);
    chk("valid", valid, m_valid);
    chk("sample", sample, m_sample);
  end
  initial begin
    int seq_a[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    int seq_b[6] = '{1, 1, 1, 3, 3, 3};
    bit hit;
    rst = 1; start = 0; mask = 0; ready = 0; ypat = 0;
    repeat (2) @(negedge clk);
    chk("rst_out", {s1, s0, busy, valid, sample}, 0);
    rst = 0; mask = 4'hF; ypat = 4'hC; start = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 0;
      chk("seq_a", {s1, s0}, seq_a[i]);
    end
    chk("valid_early_a", valid, 0);
    @(negedge clk);
    chk("valid_a", valid, 1);
    chk("sample_a", sample, 4'hC);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      mask = 4'($urandom);
      @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_sample", sample, 4'hC);
    end
    start = 0; mask = 0; ready = 1;
    @(negedge clk);
    chk("release", {busy, valid}, 0);
    ready = 0; mask = 4'hA; ypat = 4'hF; start = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 0;
      chk("seq_b", {s1, s0}, seq_b[i]);
    end
    chk("valid_early_b", valid, 0);
    @(negedge clk);
    chk("valid_b", valid, 1);
    chk("sample_b", sample, 4'hA);
    mask = 0; ready = 1;
    @(negedge clk);
    ready = 0; start = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("zero_mask", {busy, valid}, 0);
    end
    start = 1; mask = 4'hF; ypat = 4'h5;
    @(negedge clk);
    start = 0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = {s1, s0} == 2'd2;
    end
    chk("reach_ch2", hit, 1);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("async_rst", {s1, s0, busy, valid, sample}, 0);
    @(negedge clk);
    rst = 0; start = 1;
    @(negedge clk);
    start = 0;
    chk("restart", {s1, s0, busy}, 3'b001);
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      hit = valid;
    end
    chk("restart_done", {hit, sample}, {1'b1, 4'h5});
    mask = 0; ready = 1;
    @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 3) == 0;
      mask = 4'($urandom);
      ready = 1'($urandom_range(0, 1));
      ypat = 4'($urandom);
      rst = $urandom_range(0, 199) == 0;
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
